// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   // Clocks per oversample tick, rounded to nearest and never below one.
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      longint denom;
      longint q;
      denom = longint'(baud) * longint'(oversample);
      q     = (longint'(clk_freq) + denom / 2) / denom;
      if (q < 1) q = 1;
      return int'(q);
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-clock tick every DIV clocks; clear realigns phase.
module baud_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_in,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Count 0..DIV-1 and wrap; clear restarts the count so ticks line up with a start edge.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         cnt <= '0;
      end else if (clear || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with mid-bit sampling and framing-error detection.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_in,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_tick,
   output logic       frame_err,
   output logic       busy
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int SCW = $clog2(OVERSAMPLE);
   localparam logic [SCW-1:0] SAMP_LAST = SCW'(OVERSAMPLE - 1);
   localparam logic [SCW-1:0] SAMP_HALF = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

   logic rx_meta;
   logic rx_s;
   logic rx_prev;
   logic tick;
   logic start_edge;

   rx_state_t state;
   rx_state_t state_next;
   logic [SCW-1:0]       samp_cnt;
   logic [SCW-1:0]       samp_cnt_next;
   logic [2:0]           bit_idx;
   logic [2:0]           bit_idx_next;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shift_next;
   logic [7:0]           data_next;
   logic                 data_tick_next;
   logic                 frame_err_next;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection; resets to idle level.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         rx_meta <= IDLE_LEVEL;
         rx_s    <= IDLE_LEVEL;
         rx_prev <= IDLE_LEVEL;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign start_edge = (state == IDLE) && rx_prev && !rx_s;

   baud_tick_gen #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .rst_in (rst_in),
      .clear  (start_edge),
      .tick   (tick)
   );

   // Frame sequencing: half a bit to the start-bit centre, then one bit period per data and stop sample.
   always_comb begin
      state_next     = state;
      samp_cnt_next  = samp_cnt;
      bit_idx_next   = bit_idx;
      shift_next     = shift_reg;
      data_next      = data;
      data_tick_next = 1'b0;
      frame_err_next = 1'b0;
      case (state)
         IDLE: begin
            if (start_edge) begin
               state_next    = START;
               samp_cnt_next = '0;
            end
         end
         START: begin
            if (tick) begin
               if (samp_cnt == SAMP_HALF) begin
                  samp_cnt_next = '0;
                  bit_idx_next  = '0;
                  state_next    = rx_s ? IDLE : DATA;
               end else begin
                  samp_cnt_next = samp_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (samp_cnt == SAMP_LAST) begin
                  samp_cnt_next       = '0;
                  shift_next[bit_idx] = rx_s;
                  if (bit_idx == BIT_LAST) begin
                     state_next = STOP;
                  end else begin
                     bit_idx_next = bit_idx + 1'b1;
                  end
               end else begin
                  samp_cnt_next = samp_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (samp_cnt == SAMP_LAST) begin
                  samp_cnt_next = '0;
                  state_next    = IDLE;
                  if (rx_s) begin
                     data_next      = shift_reg;
                     data_tick_next = 1'b1;
                  end else begin
                     frame_err_next = 1'b1;
                  end
               end else begin
                  samp_cnt_next = samp_cnt + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Register FSM state, counters and the output pulses; reset discards any partial frame.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state     <= IDLE;
         samp_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         data      <= '0;
         data_tick <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_next;
         samp_cnt  <= samp_cnt_next;
         bit_idx   <= bit_idx_next;
         shift_reg <= shift_next;
         data      <= data_next;
         data_tick <= data_tick_next;
         frame_err <= frame_err_next;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 format, LSB first, line idles high.
- Turns the external RX pin into the data/data_tick byte stream consumed by the ROM programmer stage.
- Oversampled, mid-bit sampling; framing errors are flagged and the byte is dropped.
- Sits between the board RX pin and the programmer; single clock domain after the input synchroniser.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.

Ports:
- clk  in  1  system clock; all flops on posedge.
- rst_in  in  1  asynchronous, active-high reset.
- rx  in  1  raw serial line, asynchronous to clk.
- data  out  8  last received byte; valid while data_tick=1, held until the next accepted byte.
- data_tick  out  1  single-cycle pulse per accepted byte.
- frame_err  out  1  single-cycle pulse when the stop bit samples low.
- busy  out  1  high from start-bit detection until the frame is finished.

Behaviour:
- Reset: data=0, data_tick=0, frame_err=0, busy=0, state=IDLE, all counters 0. Synchroniser flops reset to 1 (idle line). Reset may assert mid-frame; the partial byte is discarded and no pulse is emitted.
- Synchroniser: 2-FF chain on rx; all logic uses the second-stage output (rx_s). rx_s lags the pin by 2 clk.
- Tick generator:
  - DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)), minimum 1.
  - Free-running counter 0..DIV-1 emits a one-clk tick at wrap.
  - The counter is cleared on start detection so sampling phase aligns to the falling edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rx_s transition from 1 to 0 (previous rx_s registered), go to START, clear tick counter and sample counter, busy<=1.
  - START: after OVERSAMPLE/2 ticks, sample rx_s.
    - If 1 (glitch): go to IDLE, busy<=0, no pulse.
    - If 0: go to DATA, bit index=0, sample counter=0.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift register bit[index], LSB first. After bit 7, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: data<=shift register and data_tick=1 for exactly one clk.
    - If 0: frame_err=1 for one clk; data is unchanged.
    - Either way: go to IDLE, busy<=0.
- After a frame error, IDLE only re-arms on a fresh 1-to-0 edge, so a held-low (break) line produces no further frames.
- Latency: data_tick asserts 1 clk after the mid-stop-bit sample tick, about 9.5 bit times after the start edge plus 2 clk of synchroniser delay.
- Back-to-back frames: a start edge arriving in the second half of the stop bit is caught because IDLE is entered at mid-stop.
- data_tick and frame_err are never high together.
- Tolerates ±3% baud mismatch at OVERSAMPLE=16.

Decomposition:
- uart_pkg holds:
  - rx state enum (logic [1:0]: IDLE, START, DATA, STOP);
  - localparams for 8 data bits, idle level 1'b1;
  - a function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE.
- Sub-module baud_tick_gen: parameter DIV; inputs clk, rst_in, clear; output tick. Reusable by a future uart_tx.
- The synchroniser stays inline.

Test Plan:
- Setup: CLK_FREQ=6_400_000, BAUD=100_000, OVERSAMPLE=16, so DIV=4 and one bit = 64 clk.
- Single byte: drive frame 0x73 ('s') -> exactly one data_tick, data=8'h73, frame_err never asserts, busy falls the same cycle.
- Stream: 'ssss' + 'x' + 0x11,0x22,0x33,0x44 + 'e' with no idle gap -> 10 data_ticks, bytes in order, no stop-bit slip.
- Framing error: frame 0xA5 with stop bit driven 0 -> one frame_err pulse, no data_tick, data keeps its previous value. Line then held low for 300 clk -> no further pulses. Line released, then 0x5A -> data=8'h5A.
- Glitch: low pulse of 20 clk on the idle line -> no data_tick, busy returns to 0 within 32+2 clk, the next valid byte is received correctly.
- Reset mid-frame: assert rst_in during bit 4 of 0xFF for 3 clk, then release and send 0x0F -> no pulse for the aborted frame, data=8'h0F after the second frame, outputs 0 during reset.
- Baud skew: sender bit period 62 and 66 clk, byte 0xC3 -> data=8'hC3 in both cases.
